div_result_collector: RTL and testbench

- Downstream companion to the 8-bit/5-bit fixed-latency pipelined divider. The divider cannot stall and its own valid output does not track input requests.
- This block tracks every issued request through the divider latency and flags divide-by-zero.
- It captures each quotient/remainder into a result FIFO and presents results on a ready/valid interface.
- A credit counter (o_in_ready) guarantees no result is ever lost to back-pressure.

---
 rtl/div_result_collector_pkg.sv | 32 +++
 rtl/div_result_collector_fifo.sv | 59 +++++
 rtl/div_result_collector.sv | 97 +++++++++
 tb/tb_div_result_collector.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_result_collector_pkg.sv
// rtl/div_result_collector_pkg.sv - shared constants, FIFO entry layout and helpers for the divider result collector
package div_result_collector_pkg;

    localparam int LAT     = 8;
    localparam int Q_W     = 8;
    localparam int R_W     = 5;
    localparam int ENTRY_W = 1 + Q_W + R_W;
    localparam int NUM_W   = 51;

    localparam logic [Q_W-1:0] DZ_Q = 8'hFF;
    localparam logic [R_W-1:0] DZ_R = 5'h00;

    // Both blocks are behavioural; no library cells are instantiated.
    localparam logic [NUM_W-1:0] TOP_CELL_XTORS  = '0;
    localparam logic [NUM_W-1:0] FIFO_CELL_XTORS = '0;

    typedef struct packed {
        logic           dz;
        logic [Q_W-1:0] q;
        logic [R_W-1:0] r;
    } res_entry_t;

    function automatic res_entry_t make_entry(input logic dz, input logic [Q_W-1:0] q,
                                              input logic [R_W-1:0] r);
        res_entry_t e;
        e.dz = dz;
        e.q  = dz ? DZ_Q : q;
        e.r  = dz ? DZ_R : r;
        return e;
    endfunction

endpackage

// File: rtl/div_result_collector_fifo.sv
// rtl/div_result_collector_fifo.sv - DEPTH x 14 result FIFO with occupancy-based full/empty
module div_res_fifo
    import div_result_collector_pkg::*;
#(
    parameter int DEPTH = 10,
    parameter int CW    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] din,
    input  logic               pop,
    output logic [ENTRY_W-1:0] dout,
    output logic               valid,
    output logic [NUM_W-1:0]   number
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               push_ok;
    logic               pop_ok;

    assign push_ok = push && (count != FULL_CNT);
    assign pop_ok  = pop && (count != '0);
    assign valid   = (count != '0);
    assign dout    = valid ? mem[rd_ptr] : '0;
    assign number  = FIFO_CELL_XTORS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/div_result_collector.sv
// rtl/div_result_collector.sv - tracks divider requests through fixed latency and queues results behind credit flow control
module div_result_collector
    import div_result_collector_pkg::*;
#(
    parameter int LAT   = div_result_collector_pkg::LAT,
    parameter int DEPTH = 10,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    input  logic [R_W-1:0]   i_b,
    output logic             o_in_ready,
    input  logic [Q_W-1:0]   i_q,
    input  logic [R_W-1:0]   i_r,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [Q_W-1:0]   o_q,
    output logic [R_W-1:0]   o_r,
    output logic             o_dz,
    output logic             o_drop_err,
    output logic [NUM_W-1:0] number
);

    localparam logic [CW-1:0] MAX_CREDIT = CW'(DEPTH);

    logic [LAT-1:0]     tok_v;
    logic [LAT-1:0]     tok_dz;
    logic [CW-1:0]      credit;
    logic               acc;
    logic               push;
    logic               pop;
    res_entry_t         push_entry;
    res_entry_t         head_entry;
    logic [ENTRY_W-1:0] head_bits;
    logic [NUM_W-1:0]   fifo_number;

    assign o_in_ready = (credit < MAX_CREDIT);
    assign acc        = i_in_valid & o_in_ready;

    // The token leaving the last stage lines up with the divider output for that request.
    assign push       = tok_v[LAT-1];
    assign push_entry = make_entry(tok_dz[LAT-1], i_q, i_r);
    assign pop        = o_valid & i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_v  <= '0;
            tok_dz <= '0;
        end else begin
            tok_v  <= {tok_v[LAT-2:0], acc};
            tok_dz <= {tok_dz[LAT-2:0], acc & (i_b == '0)};
        end
    end

    // Credit covers both in-flight tokens and stored results, so a push never finds the FIFO full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit <= '0;
        end else begin
            case ({acc, pop})
                2'b10:   credit <= credit + 1'b1;
                2'b01:   credit <= credit - 1'b1;
                default: credit <= credit;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_drop_err <= 1'b0;
        end else if (i_in_valid && !o_in_ready) begin
            o_drop_err <= 1'b1;
        end
    end

    div_res_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .din    (push_entry),
        .pop    (pop),
        .dout   (head_bits),
        .valid  (o_valid),
        .number (fifo_number)
    );

    assign head_entry = res_entry_t'(head_bits);
    assign o_dz       = head_entry.dz;
    assign o_q        = head_entry.q;
    assign o_r        = head_entry.r;
    assign number     = fifo_number + TOP_CELL_XTORS;

endmodule

// File: tb/tb_div_result_collector.sv
// tb/tb_div_result_collector.sv - randomized self-checking bench for div_result_collector
module tb_div_result_collector;

    localparam int LAT   = 8;
    localparam int DEPTH = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_in_valid;
    logic [4:0]  i_b;
    logic        o_in_ready;
    logic [7:0]  i_q;
    logic [4:0]  i_r;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_q;
    logic [4:0]  o_r;
    logic        o_dz;
    logic        o_drop_err;
    logic [50:0] number;

    div_result_collector #(.LAT(LAT), .DEPTH(DEPTH), .CW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_in_valid (i_in_valid),
        .i_b        (i_b),
        .o_in_ready (o_in_ready),
        .i_q        (i_q),
        .i_r        (i_r),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_q        (o_q),
        .o_r        (o_r),
        .o_dz       (o_dz),
        .o_drop_err (o_drop_err),
        .number     (number)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [4:0] r;
        logic       dz;
        int         vis;
    } exp_t;

    exp_t       mq[$];
    logic       exp_drop;
    logic [7:0] sq[16];
    logic [4:0] sr[16];
    int         cyc;
    int         n_checks;
    int         n_pass;
    int         npop, first_pop, last_pop;
    int         dut_acc, dut_ready_low, dut_valid_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One cycle: compare DUT to model, drive inputs, advance model, move to #1 after next edge.
    task automatic step(input logic v, input logic [4:0] b, input logic [7:0] a,
                        input logic rdy, input logic rstn);
        logic       e_ready, e_valid;
        logic [7:0] e_q;
        logic [4:0] e_r;
        logic       e_dz;
        exp_t       ne;
        e_ready = (mq.size() < DEPTH);
        e_valid = (mq.size() > 0) && (mq[0].vis <= cyc);
        e_q  = e_valid ? mq[0].q  : 8'h00;
        e_r  = e_valid ? mq[0].r  : 5'h00;
        e_dz = e_valid ? mq[0].dz : 1'b0;
        chk("o_in_ready", 64'(o_in_ready), 64'(e_ready));
        chk("o_valid",    64'(o_valid),    64'(e_valid));
        chk("o_q",        64'(o_q),        64'(e_q));
        chk("o_r",        64'(o_r),        64'(e_r));
        chk("o_dz",       64'(o_dz),       64'(e_dz));
        chk("o_drop_err", 64'(o_drop_err), 64'(exp_drop));
        chk("no_push_full", 64'(dut.push && (dut.u_fifo.count == 4'(DEPTH))), 64'(0));
        chk("credit_max",   64'(dut.credit <= 4'(DEPTH)), 64'(1));
        if (!o_in_ready) dut_ready_low++;
        if (o_valid) dut_valid_seen++;
        if (v && o_in_ready && rstn) dut_acc++;

        rst_n      = rstn;
        i_in_valid = v;
        i_b        = b;
        i_ready    = rdy;
        i_q        = sq[cyc % 16];
        i_r        = sr[cyc % 16];
        if (v && b != 0) begin
            sq[(cyc + LAT) % 16] = a / 8'(b);
            sr[(cyc + LAT) % 16] = 5'(a % 8'(b));
        end else begin
            sq[(cyc + LAT) % 16] = 8'($urandom);
            sr[(cyc + LAT) % 16] = 5'($urandom);
        end

        if (!rstn) begin
            mq.delete();
            exp_drop = 1'b0;
        end else begin
            if (e_valid && rdy) begin
                void'(mq.pop_front());
                npop++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            if (v && e_ready) begin
                ne.dz  = (b == 0);
                ne.q   = (b == 0) ? 8'hFF : a / 8'(b);
                ne.r   = (b == 0) ? 5'h00 : 5'(a % 8'(b));
                ne.vis = cyc + LAT + 1;
                mq.push_back(ne);
            end
            if (v && !e_ready) exp_drop = 1'b1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        step(1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
        step(1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
        cyc = 0;
        npop = 0; first_pop = -1; last_pop = -1;
        dut_acc = 0; dut_ready_low = 0; dut_valid_seen = 0;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 8'd0, rdy, 1'b1);
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0; exp_drop = 1'b0;
        npop = 0; first_pop = -1; last_pop = -1;
        dut_acc = 0; dut_ready_low = 0; dut_valid_seen = 0;
        for (int i = 0; i < 16; i++) begin
            sq[i] = 8'($urandom);
            sr[i] = 5'($urandom);
        end
        rst_n = 1'b0; i_in_valid = 1'b0; i_b = '0; i_ready = 1'b0; i_q = '0; i_r = '0;
        @(posedge clk);
        #1;
        chk("rst_o_valid",    64'(o_valid), 64'(0));
        chk("rst_o_q",        64'(o_q), 64'(0));
        chk("rst_o_r",        64'(o_r), 64'(0));
        chk("rst_o_dz",       64'(o_dz), 64'(0));
        chk("rst_o_drop_err", 64'(o_drop_err), 64'(0));
        chk("rst_o_in_ready", 64'(o_in_ready), 64'(1));
        chk("number",         64'(number), 64'(0));

        // single request 200/7
        restart();
        step(1'b1, 5'd7, 8'd200, 1'b1, 1'b1);
        idle(7, 1'b1);
        chk("s1_valid_c8", 64'(o_valid), 64'(0));
        idle(1, 1'b1);
        chk("s1_valid_c9", 64'(o_valid), 64'(1));
        chk("s1_q", 64'(o_q), 64'(28));
        chk("s1_r", 64'(o_r), 64'(4));
        chk("s1_dz", 64'(o_dz), 64'(0));
        idle(1, 1'b1);
        chk("s1_credit_c10", 64'(dut.credit), 64'(0));
        idle(3, 1'b1);

        // 255/31 then divide-by-zero
        restart();
        step(1'b1, 5'd31, 8'd255, 1'b1, 1'b1);
        step(1'b1, 5'd0, 8'd50, 1'b1, 1'b1);
        idle(7, 1'b1);
        chk("s2_q0", 64'(o_q), 64'(8));
        chk("s2_r0", 64'(o_r), 64'(7));
        chk("s2_dz0", 64'(o_dz), 64'(0));
        idle(1, 1'b1);
        chk("s2_q1", 64'(o_q), 64'(8'hFF));
        chk("s2_r1", 64'(o_r), 64'(0));
        chk("s2_dz1", 64'(o_dz), 64'(1));
        idle(3, 1'b1);

        // 20 back-to-back
        restart();
        for (int i = 0; i < 20; i++) step(1'b1, 5'($urandom_range(1, 31)), 8'($urandom), 1'b1, 1'b1);
        idle(14, 1'b1);
        chk("s3_ready_low", 64'(dut_ready_low), 64'(0));
        chk("s3_pops", 64'(npop), 64'(20));
        chk("s3_first_pop", 64'(first_pop), 64'(9));
        chk("s3_last_pop", 64'(last_pop), 64'(28));

        // fill with consumer stalled, then drain
        restart();
        for (int i = 0; i < 10; i++) step(1'b1, 5'($urandom_range(0, 31)), 8'($urandom), 1'b0, 1'b1);
        chk("s4_ready_c10", 64'(o_in_ready), 64'(0));
        for (int i = 0; i < 8; i++) step(1'b1, 5'($urandom_range(0, 31)), 8'($urandom), 1'b0, 1'b1);
        chk("s4_accepted", 64'(dut_acc), 64'(10));
        chk("s4_drop", 64'(o_drop_err), 64'(1));
        idle(25, 1'b1);
        chk("s4_pops", 64'(npop), 64'(10));
        chk("s4_drop_sticky", 64'(o_drop_err), 64'(1));

        // reset while requests in flight
        restart();
        for (int i = 0; i < 4; i++) step(1'b1, 5'($urandom_range(1, 31)), 8'($urandom), 1'b1, 1'b1);
        step(1'b1, 5'd3, 8'd9, 1'b1, 1'b0);
        step(1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
        idle(20, 1'b1);
        chk("s5_valid_seen", 64'(dut_valid_seen), 64'(0));
        chk("s5_ready", 64'(o_in_ready), 64'(1));
        chk("s5_q", 64'(o_q), 64'(0));

        // random traffic
        restart();
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 8'($urandom),
                 1'($urandom_range(0, 9) < 6),
                 1'b1);
        end
        idle(30, 1'b1);
        chk("rand_drained", 64'(o_valid), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
